cv32e40p_shadow_obi_arbiter: RTL and testbench

- Two-master to one-slave OBI arbiter. Merges the core's data port (data_*) and shadow-store port (shadow_*) onto a single memory port (mem_*).
- Sits between cv32e40p_core and the data-side interconnect when SHADOW=1.
- Arbitrates round-robin on address phase, with a per-master lock while a request waits for grant.
- Tracks outstanding transactions in an ID FIFO so each response is routed back to the master that issued it.

---
 rtl/cv32e40p_shadow_obi_arbiter.sv | 150 +++++++++++++++
 tb/tb_cv32e40p_shadow_obi_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_shadow_obi_arbiter.sv
// rtl/cv32e40p_shadow_obi_arbiter.sv - two-master OBI arbiter merging core data and shadow-store ports
// Optional conflict counter enabled by defining CV32E40P_ARB_PERF_EN.
module cv32e40p_shadow_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          SHADOW_FIRST    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        shadow_req_i,
  input  logic        shadow_we_i,
  input  logic [3:0]  shadow_be_i,
  input  logic [31:0] shadow_addr_i,
  input  logic [31:0] shadow_wdata_i,
  output logic        shadow_gnt_o,
  output logic        shadow_rvalid_o,
  output logic [31:0] shadow_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_err_o,
  output logic [31:0] conflict_cnt_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  // Master ids: 0 = data port, 1 = shadow port.
  logic [CW-1:0]              count_q;
  logic [PW-1:0]              wr_ptr_q;
  logic [PW-1:0]              rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] id_fifo_q;
  logic                       lock_q;
  logic                       lock_sel_q;
  logic                       rr_q;

  logic sel;
  logic sel_req;
  logic full;
  logic has_outstanding;
  logic handshake;
  logic pop;
  logic head;

  assign full            = (count_q == CNT_MAX);
  assign has_outstanding = (count_q != '0);
  assign head            = id_fifo_q[rd_ptr_q];

  // Pick the master driving the address phase; a stalled request owns the port until granted.
  always_comb begin
    sel = 1'b0;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (data_req_i && shadow_req_i) begin
      sel = rr_q;
    end else if (shadow_req_i) begin
      sel = 1'b1;
    end
  end

  assign sel_req   = sel ? shadow_req_i : data_req_i;
  // Room check uses the registered count, so a same-cycle pop never frees a slot early.
  assign mem_req_o = sel_req & ~full & ~rst_i;
  assign handshake = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & has_outstanding & ~rst_i;

  assign mem_we_o    = sel ? shadow_we_i    : data_we_i;
  assign mem_be_o    = sel ? shadow_be_i    : data_be_i;
  assign mem_addr_o  = sel ? shadow_addr_i  : data_addr_i;
  assign mem_wdata_o = sel ? shadow_wdata_i : data_wdata_i;

  assign data_gnt_o   = handshake & ~sel;
  assign shadow_gnt_o = handshake &  sel;

  assign data_rvalid_o   = pop & ~head;
  assign shadow_rvalid_o = pop &  head;
  assign data_rdata_o    = mem_rdata_i;
  assign shadow_rdata_o  = mem_rdata_i;

  assign resp_err_o = mem_rvalid_i & ~has_outstanding & ~rst_i;

  // Outstanding-id FIFO, request lock and round-robin priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      id_fifo_q  <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      rr_q       <= SHADOW_FIRST;
    end else begin
      if (handshake) begin
        id_fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q            <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        rr_q                <= ~sel;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({handshake, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (handshake) begin
        lock_q <= 1'b0;
      end else if (mem_req_o) begin
        lock_q     <= 1'b1;
        lock_sel_q <= sel;
      end
    end
  end

`ifdef CV32E40P_ARB_PERF_EN
  logic [31:0] conflict_cnt_q;
  logic        conflict;

  assign conflict = (data_req_i & shadow_req_i) |
                    (lock_q & (lock_sel_q ? data_req_i : shadow_req_i));

  // Saturating count of cycles where a master is kept waiting by the other.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt_q <= '0;
    end else if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_shadow_obi_arbiter.sv
// tb/tb_cv32e40p_shadow_obi_arbiter.sv - directed self-checking bench for the shadow OBI arbiter
module tb_cv32e40p_shadow_obi_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        shadow_req_i, shadow_we_i;
  logic [3:0]  shadow_be_i;
  logic [31:0] shadow_addr_i, shadow_wdata_i;
  logic        shadow_gnt_o, shadow_rvalid_o;
  logic [31:0] shadow_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        resp_err_o;
  logic [31:0] conflict_cnt_o;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  cv32e40p_shadow_obi_arbiter #(
    .MAX_OUTSTANDING(2),
    .SHADOW_FIRST   (1'b0)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .shadow_req_i   (shadow_req_i),
    .shadow_we_i    (shadow_we_i),
    .shadow_be_i    (shadow_be_i),
    .shadow_addr_i  (shadow_addr_i),
    .shadow_wdata_i (shadow_wdata_i),
    .shadow_gnt_o   (shadow_gnt_o),
    .shadow_rvalid_o(shadow_rvalid_o),
    .shadow_rdata_o (shadow_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .resp_err_o     (resp_err_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    data_req_i   = 1'b0;
    shadow_req_i = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp_en);
`ifdef CV32E40P_ARB_PERF_EN
    check(tag, conflict_cnt_o, exp_en);
`else
    check(tag, conflict_cnt_o, 32'd0 & exp_en);
`endif
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    shadow_we_i = 1'b1; shadow_be_i = 4'hF; shadow_addr_i = 32'h0; shadow_wdata_i = 32'h0;
    mem_rdata_i = 32'h0;

    // Reset forces handshake outputs low even with active inputs.
    cyc();
    data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_data_gnt", {31'd0, data_gnt_o}, 32'd0);
    check("rst_data_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err_o}, 32'd0);
    cyc();
    idle();
    cyc();
    rst_i = 1'b0;

    // Single data read.
    data_req_i = 1'b1; data_addr_i = 32'h1000; mem_gnt_i = 1'b1;
    #1;
    check("rd_mem_req", {31'd0, mem_req_o}, 32'd1);
    check("rd_mem_addr", mem_addr_o, 32'h1000);
    check("rd_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    check("rd_shadow_gnt", {31'd0, shadow_gnt_o}, 32'd0);
    cyc();
    idle();
    #1;
    check("rd_gap_mem_req", {31'd0, mem_req_o}, 32'd0);
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("rd_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    check("rd_data_rdata", data_rdata_o, 32'hDEAD_BEEF);
    check("rd_shadow_rvalid", {31'd0, shadow_rvalid_o}, 32'd0);
    check("rd_resp_err", {31'd0, resp_err_o}, 32'd0);
    cyc();
    idle();

    // Re-reset so round-robin priority starts from data again.
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;

    // Continuous conflict: grants alternate, responses follow grant order.
    data_req_i = 1'b1; data_addr_i = 32'h2000;
    shadow_req_i = 1'b1; shadow_addr_i = 32'h3000;
    mem_gnt_i = 1'b1;
    #1;
    check("cf1_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    check("cf1_mem_addr", mem_addr_o, 32'h2000);
    cyc();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0A01;
    #1;
    check("cf2_shadow_gnt", {31'd0, shadow_gnt_o}, 32'd1);
    check("cf2_mem_addr", mem_addr_o, 32'h3000);
    check("cf2_mem_we", {31'd0, mem_we_o}, 32'd1);
    check("cf2_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    cyc();
    #1;
    check("cf3_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    check("cf3_shadow_rvalid", {31'd0, shadow_rvalid_o}, 32'd1);
    check("cf3_data_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    cyc();
    #1;
    check("cf4_shadow_gnt", {31'd0, shadow_gnt_o}, 32'd1);
    check("cf4_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    cyc();
    data_req_i = 1'b0; shadow_req_i = 1'b0; mem_gnt_i = 1'b0;
    #1;
    check("cf5_shadow_rvalid", {31'd0, shadow_rvalid_o}, 32'd1);
    check_cnt("cf5_conflict_cnt", 32'd4);
    cyc();
    idle();

    // Data write handshake leaves priority with shadow.
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h6000; data_wdata_i = 32'h1234_5678;
    mem_gnt_i = 1'b1;
    #1;
    check("wr_mem_we", {31'd0, mem_we_o}, 32'd1);
    check("wr_mem_wdata", mem_wdata_o, 32'h1234_5678);
    check("wr_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    cyc();
    idle();
    data_we_i = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    check("wr_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    cyc();
    idle();

    // Lock: stalled data request keeps the port although shadow has priority.
    data_req_i = 1'b1; data_addr_i = 32'h4000;
    #1;
    check("lk1_mem_addr", mem_addr_o, 32'h4000);
    check("lk1_mem_req", {31'd0, mem_req_o}, 32'd1);
    check("lk1_data_gnt", {31'd0, data_gnt_o}, 32'd0);
    cyc();
    shadow_req_i = 1'b1; shadow_addr_i = 32'h5000;
    #1;
    check("lk2_mem_addr", mem_addr_o, 32'h4000);
    check("lk2_shadow_gnt", {31'd0, shadow_gnt_o}, 32'd0);
    cyc();
    #1;
    check("lk3_mem_addr", mem_addr_o, 32'h4000);
    cyc();
    mem_gnt_i = 1'b1;
    #1;
    check("lk4_mem_addr", mem_addr_o, 32'h4000);
    check("lk4_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    check("lk4_shadow_gnt", {31'd0, shadow_gnt_o}, 32'd0);
    cyc();
    data_req_i = 1'b0;
    #1;
    check("lk5_shadow_gnt", {31'd0, shadow_gnt_o}, 32'd1);
    check("lk5_mem_addr", mem_addr_o, 32'h5000);
    check_cnt("lk5_conflict_cnt", 32'd7);
    cyc();
    idle();
    mem_rvalid_i = 1'b1;
    #1;
    check("lk6_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    cyc();
    #1;
    check("lk7_shadow_rvalid", {31'd0, shadow_rvalid_o}, 32'd1);
    cyc();
    idle();

    // Full: two grants without responses block the third request.
    data_req_i = 1'b1; data_addr_i = 32'h7000; mem_gnt_i = 1'b1;
    #1;
    check("fl1_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    cyc();
    data_addr_i = 32'h7004;
    #1;
    check("fl2_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    cyc();
    data_addr_i = 32'h7008;
    #1;
    check("fl3_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("fl3_data_gnt", {31'd0, data_gnt_o}, 32'd0);
    cyc();
    #1;
    check("fl4_mem_req", {31'd0, mem_req_o}, 32'd0);
    cyc();
    mem_rvalid_i = 1'b1;
    #1;
    check("fl5_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("fl5_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    cyc();
    mem_rvalid_i = 1'b0;
    #1;
    check("fl6_mem_req", {31'd0, mem_req_o}, 32'd1);
    check("fl6_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    cyc();
    data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    #1;
    check("fl7_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    cyc();
    #1;
    check("fl8_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    check("fl8_resp_err", {31'd0, resp_err_o}, 32'd0);
    cyc();

    // Spurious response with nothing outstanding.
    #1;
    check("sp_resp_err", {31'd0, resp_err_o}, 32'd1);
    check("sp_data_rvalid", {31'd0, data_rvalid_o}, 32'd0);
    check("sp_shadow_rvalid", {31'd0, shadow_rvalid_o}, 32'd0);
    cyc();
    mem_rvalid_i = 1'b0;
    #1;
    check("sp_resp_err_clr", {31'd0, resp_err_o}, 32'd0);
    cyc();

    // Reset with two shadow transactions outstanding.
    shadow_req_i = 1'b1; shadow_addr_i = 32'h8000; mem_gnt_i = 1'b1;
    #1;
    check("rm1_shadow_gnt", {31'd0, shadow_gnt_o}, 32'd1);
    cyc();
    #1;
    check("rm2_shadow_gnt", {31'd0, shadow_gnt_o}, 32'd1);
    cyc();
    rst_i = 1'b1; data_req_i = 1'b1; mem_rvalid_i = 1'b1;
    #1;
    check("rm3_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rm3_gnts", {30'd0, data_gnt_o, shadow_gnt_o}, 32'd0);
    check("rm3_rvalids", {30'd0, data_rvalid_o, shadow_rvalid_o}, 32'd0);
    check("rm3_resp_err", {31'd0, resp_err_o}, 32'd0);
    cyc();
    rst_i = 1'b0;
    idle();
    #1;
    check("rm4_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rm4_rvalids", {30'd0, data_rvalid_o, shadow_rvalid_o}, 32'd0);
    check_cnt("rm4_conflict_cnt", 32'd0);
    cyc();
    data_req_i = 1'b1; data_addr_i = 32'h9000; mem_gnt_i = 1'b1;
    #1;
    check("rm5_data_gnt", {31'd0, data_gnt_o}, 32'd1);
    cyc();
    idle();
    mem_rvalid_i = 1'b1;
    #1;
    check("rm6_data_rvalid", {31'd0, data_rvalid_o}, 32'd1);
    check("rm6_shadow_rvalid", {31'd0, shadow_rvalid_o}, 32'd0);
    cyc();
    #1;
    check("rm7_resp_err", {31'd0, resp_err_o}, 32'd1);
    cyc();
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
